// File: rtl/guess_ctrl.sv
// Game controller for the number-guessing design: sequences target generation,
// guess entry, checker handshake, scoring, pause/resume and end-of-game.
module guess_ctrl #(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 8,
  localparam int CW = $clog2(DIGITS + 1),
  localparam int TW = $clog2(MAX_TRIES + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic          pulse,
  input  logic          again,
  input  logic          rand_ready,
  input  logic          check_valid,
  input  logic [CW-1:0] check_hits,
  input  logic [CW-1:0] check_blows,
  input  logic          timer_finish,
  output logic          generate_random,
  output logic          check_start,
  output logic          timer_en,
  output logic          timer_set,
  output logic [1:0]    led_sel,
  output logic [1:0]    seg_sel,
  output logic [CW-1:0] last_hits,
  output logic [CW-1:0] last_blows,
  output logic [TW-1:0] tries_used,
  output logic [TW-1:0] best_tries,
  output logic          lose_cause,
  output logic [2:0]    state_dbg
);

  // Handshakes: generate_random is held until rand_ready is seen in GEN;
  // check_start is a one-cycle strobe on CHECK entry and check_valid is only
  // accepted while in CHECK, so a late response after an abort is dropped.
  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_GEN    = 3'd1,
    ST_INPUT  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RESULT = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_WIN    = 3'd6,
    ST_LOSE   = 3'd7
  } state_t;

  state_t state, next_state, resume_state;
  logic   in_check_q;
  logic   hit_all, tries_out;
  logic   accept_check, lose_time, lose_tries;

  assign hit_all   = (last_hits == CW'(DIGITS));
  assign tries_out = (MAX_TRIES != 0) && (tries_used == TW'(MAX_TRIES));

  always_comb begin
    next_state   = state;
    accept_check = 1'b0;
    lose_time    = 1'b0;
    lose_tries   = 1'b0;
    if (again) begin
      next_state = ST_START;
    end else begin
      unique case (state)
        ST_START: next_state = ST_GEN;
        ST_GEN: if (rand_ready) next_state = ST_INPUT;
        ST_INPUT: begin
          if (timer_finish) begin
            next_state = ST_LOSE;
            lose_time  = 1'b1;
          end else if (btn) begin
            next_state = ST_CHECK;
          end else if (pulse) begin
            next_state = ST_PAUSE;
          end
        end
        ST_CHECK: begin
          if (timer_finish) begin
            next_state = ST_LOSE;
            lose_time  = 1'b1;
          end else if (check_valid) begin
            next_state   = ST_RESULT;
            accept_check = 1'b1;
          end
        end
        // A winning score outranks an expiring timer in the same cycle.
        ST_RESULT: begin
          if (hit_all) begin
            next_state = ST_WIN;
          end else if (timer_finish) begin
            next_state = ST_LOSE;
            lose_time  = 1'b1;
          end else if (tries_out) begin
            next_state = ST_LOSE;
            lose_tries = 1'b1;
          end else if (btn) begin
            next_state = ST_INPUT;
          end else if (pulse) begin
            next_state = ST_PAUSE;
          end
        end
        ST_PAUSE: if (pulse) next_state = resume_state;
        ST_WIN:   if (btn) next_state = ST_START;
        ST_LOSE:  if (btn) next_state = ST_START;
        default:  next_state = ST_START;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_START;
      resume_state <= ST_INPUT;
      in_check_q   <= 1'b0;
      last_hits    <= '0;
      last_blows   <= '0;
      tries_used   <= '0;
      best_tries   <= {TW{1'b1}};
      lose_cause   <= 1'b0;
    end else begin
      state      <= next_state;
      in_check_q <= (state == ST_CHECK);
      if (next_state == ST_PAUSE && state != ST_PAUSE) resume_state <= state;
      if (lose_time)  lose_cause <= 1'b0;
      if (lose_tries) lose_cause <= 1'b1;
      // Score is cleared on the way into START so it already reads zero there.
      if (state == ST_START || next_state == ST_START) begin
        last_hits  <= '0;
        last_blows <= '0;
        tries_used <= '0;
      end else if (accept_check) begin
        last_hits  <= check_hits;
        last_blows <= check_blows;
        if (tries_used != {TW{1'b1}}) tries_used <= tries_used + 1'b1;
      end
      if (state == ST_RESULT && next_state == ST_WIN && tries_used < best_tries)
        best_tries <= tries_used;
    end
  end

  always_comb begin
    generate_random = 1'b0;
    timer_en        = 1'b0;
    timer_set       = 1'b0;
    led_sel         = 2'b00;
    seg_sel         = 2'b00;
    check_start     = (state == ST_CHECK) && !in_check_q;
    state_dbg       = state;
    unique case (state)
      ST_START:  timer_set       = 1'b1;
      ST_GEN:    generate_random = 1'b1;
      ST_INPUT:  timer_en        = 1'b1;
      ST_CHECK:  timer_en        = 1'b1;
      ST_RESULT: begin
        timer_en = 1'b1;
        led_sel  = 2'b11;
      end
      ST_PAUSE:  seg_sel = 2'b11;
      ST_WIN: begin
        led_sel = 2'b01;
        seg_sel = 2'b01;
      end
      ST_LOSE: begin
        led_sel = 2'b10;
        seg_sel = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_guess_ctrl.sv
// Directed vector bench for guess_ctrl with DIGITS=4, MAX_TRIES=3: each row
// gives the inputs for one cycle and the state/outputs expected in that cycle.
module tb_guess_ctrl;

  localparam int CW = 3;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn, pulse, again, rand_ready, check_valid, timer_finish;
  logic [CW-1:0] check_hits, check_blows;
  logic          generate_random, check_start, timer_en, timer_set, lose_cause;
  logic [1:0]    led_sel, seg_sel;
  logic [CW-1:0] last_hits, last_blows;
  logic [TW-1:0] tries_used, best_tries;
  logic [2:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       btn, pulse, again, rr, cv;
    logic [2:0] h, b;
    logic       tf;
    logic [2:0] st;
    logic       cs;
    logic [2:0] lh, lb, tu, bt;
    logic       lc;
  } vec_t;

  vec_t vec_q[$];

  guess_ctrl #(.DIGITS(4), .MAX_TRIES(3)) dut (
    .clk(clk), .rst(rst), .btn(btn), .pulse(pulse), .again(again),
    .rand_ready(rand_ready), .check_valid(check_valid),
    .check_hits(check_hits), .check_blows(check_blows),
    .timer_finish(timer_finish), .generate_random(generate_random),
    .check_start(check_start), .timer_en(timer_en), .timer_set(timer_set),
    .led_sel(led_sel), .seg_sel(seg_sel), .last_hits(last_hits),
    .last_blows(last_blows), .tries_used(tries_used), .best_tries(best_tries),
    .lose_cause(lose_cause), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  function automatic void add(input logic b_, p_, a_, rr_, cv_,
                              input logic [2:0] h_, bl_, input logic tf_,
                              input logic [2:0] st_, input logic cs_,
                              input logic [2:0] lh_, lb_, tu_, bt_,
                              input logic lc_);
    vec_t v;
    v.btn = b_; v.pulse = p_; v.again = a_; v.rr = rr_; v.cv = cv_;
    v.h = h_; v.b = bl_; v.tf = tf_; v.st = st_; v.cs = cs_;
    v.lh = lh_; v.lb = lb_; v.tu = tu_; v.bt = bt_; v.lc = lc_;
    vec_q.push_back(v);
  endfunction

  // Moore output table: {generate_random, timer_en, timer_set, led_sel, seg_sel}
  function automatic logic [6:0] decode(input logic [2:0] st);
    case (st)
      3'd0:    decode = 7'b001_00_00;
      3'd1:    decode = 7'b100_00_00;
      3'd2:    decode = 7'b010_00_00;
      3'd3:    decode = 7'b010_00_00;
      3'd4:    decode = 7'b010_11_00;
      3'd5:    decode = 7'b000_00_11;
      3'd6:    decode = 7'b000_01_01;
      default: decode = 7'b000_10_10;
    endcase
  endfunction

  // scoreboard
  task automatic cmp(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check(input int idx, input vec_t v);
    cmp("state", idx, {5'b0, state_dbg}, {5'b0, v.st});
    cmp("moore_out", idx, {1'b0, generate_random, timer_en, timer_set, led_sel, seg_sel},
        {1'b0, decode(v.st)});
    cmp("check_start", idx, {7'b0, check_start}, {7'b0, v.cs});
    cmp("last_hits", idx, {5'b0, last_hits}, {5'b0, v.lh});
    cmp("last_blows", idx, {5'b0, last_blows}, {5'b0, v.lb});
    cmp("tries_used", idx, {5'b0, tries_used}, {5'b0, v.tu});
    cmp("best_tries", idx, {5'b0, best_tries}, {5'b0, v.bt});
    cmp("lose_cause", idx, {7'b0, lose_cause}, {7'b0, v.lc});
  endtask

  // driver
  task automatic drive(input vec_t v);
    btn = v.btn; pulse = v.pulse; again = v.again; rand_ready = v.rr;
    check_valid = v.cv; check_hits = v.h; check_blows = v.b;
    timer_finish = v.tf;
  endtask

  initial begin
    vec_t rv;
    //   btn p ag rr cv h b tf | st cs lh lb tu bt lc
    // game 1: generator handshake, win on first guess
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,7,0);
    add(0,0,0,0,0,0,0,0, 1,0,0,0,0,7,0);
    add(0,0,0,0,0,0,0,0, 1,0,0,0,0,7,0);
    add(0,0,0,1,0,0,0,0, 1,0,0,0,0,7,0);
    add(1,0,0,0,0,0,0,0, 2,0,0,0,0,7,0);
    add(0,0,0,0,1,4,0,0, 3,1,0,0,0,7,0);
    add(0,0,0,0,0,0,0,0, 4,0,4,0,1,7,0);
    add(1,0,0,0,0,0,0,0, 6,0,4,0,1,1,0);
    // game 2: pause in RESULT, then lose on the try limit
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0);
    add(0,0,0,1,0,0,0,0, 1,0,0,0,0,1,0);
    add(1,0,0,0,0,0,0,0, 2,0,0,0,0,1,0);
    add(0,0,0,0,0,0,0,0, 3,1,0,0,0,1,0);
    add(0,0,0,0,1,1,2,0, 3,0,0,0,0,1,0);
    add(0,1,0,0,0,0,0,0, 4,0,1,2,1,1,0);
    add(1,0,0,0,0,0,0,1, 5,0,1,2,1,1,0);
    add(0,1,0,0,0,0,0,0, 5,0,1,2,1,1,0);
    add(1,1,0,0,0,0,0,0, 4,0,1,2,1,1,0);
    add(1,0,0,0,0,0,0,0, 2,0,1,2,1,1,0);
    add(0,0,0,0,1,1,2,0, 3,1,1,2,1,1,0);
    add(1,0,0,0,0,0,0,0, 4,0,1,2,2,1,0);
    add(1,0,0,0,0,0,0,0, 2,0,1,2,2,1,0);
    add(0,0,0,0,1,1,2,0, 3,1,1,2,2,1,0);
    add(1,0,0,0,0,0,0,0, 4,0,1,2,3,1,0);
    add(1,0,0,0,0,0,0,0, 7,0,1,2,3,1,1);
    // game 3: timer expires in INPUT
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,1);
    add(0,0,0,1,0,0,0,0, 1,0,0,0,0,1,1);
    add(0,0,0,0,0,0,0,1, 2,0,0,0,0,1,1);
    add(1,0,0,0,0,0,0,0, 7,0,0,0,0,1,0);
    // game 4: abort mid-CHECK, stray valids, pause in INPUT, win in 2 tries
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0);
    add(0,0,0,1,0,0,0,0, 1,0,0,0,0,1,0);
    add(1,0,0,0,0,0,0,0, 2,0,0,0,0,1,0);
    add(0,0,1,0,0,0,0,0, 3,1,0,0,0,1,0);
    add(0,0,0,0,1,4,0,0, 0,0,0,0,0,1,0);
    add(0,0,0,1,1,4,0,0, 1,0,0,0,0,1,0);
    add(0,1,0,0,0,0,0,0, 2,0,0,0,0,1,0);
    add(1,0,0,0,0,0,0,0, 5,0,0,0,0,1,0);
    add(0,1,0,0,0,0,0,0, 5,0,0,0,0,1,0);
    add(1,0,0,0,0,0,0,0, 2,0,0,0,0,1,0);
    add(0,0,0,0,1,2,1,0, 3,1,0,0,0,1,0);
    add(1,0,0,0,0,0,0,0, 4,0,2,1,1,1,0);
    add(1,0,0,0,0,0,0,0, 2,0,2,1,1,1,0);
    add(0,0,0,0,0,0,0,0, 3,1,2,1,1,1,0);
    add(0,0,0,0,1,4,0,0, 3,0,2,1,1,1,0);
    add(0,0,0,0,0,0,0,1, 4,0,4,0,2,1,0);
    add(0,0,1,0,0,0,0,0, 6,0,4,0,2,1,0);
    // again beats btn in INPUT; best_tries survives again
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0);
    add(0,0,0,1,0,0,0,0, 1,0,0,0,0,1,0);
    add(1,0,1,0,0,0,0,0, 2,0,0,0,0,1,0);
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0);
    add(0,0,0,0,0,0,0,0, 1,0,0,0,0,1,0);

    rv = '{default: '0};
    rv.bt = 3'd7;
    drive(rv);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(-1, rv);
    rst = 1'b0;

    foreach (vec_q[i]) begin
      drive(vec_q[i]);
      #1;
      check(i, vec_q[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges must restore reset values at once.
    rv = '{default: '0};
    rv.bt = 3'd7;
    drive(rv);
    rst = 1'b1;
    #1;
    check(-2, rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/guess_ctrl.md
# guess_ctrl

Parametrised game controller for the number-guessing design: sequences random-target generation, guess entry, checker handshake, result display and end-of-game. It sits between the button/pulse conditioning logic and the random generator, checker, countdown timer and display mux. Compared with the previous controller it adds DIGITS-wide hit/blow scoring, an attempt limit, pause/resume with state restore, request/ready handshakes to the generator and checker, and a best-score record.

## Interface
- DIGITS, 4, digits per guess; CW = $clog2(DIGITS+1)
- MAX_TRIES, 8, attempt limit; 0 = unlimited; TW = $clog2(MAX_TRIES+2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- btn  in  1  confirm, one-cycle pulse
- pulse  in  1  pause/resume toggle, one-cycle pulse
- again  in  1  restart request, one-cycle pulse
- rand_ready  in  1  generator finished, new target latched
- check_valid  in  1  checker result valid, one cycle
- check_hits  in  CW  correct digit in correct place
- check_blows  in  CW  correct digit, wrong place
- timer_finish  in  1  countdown expired
- generate_random  out  1  generator request
- check_start  out  1  checker start, one-cycle strobe
- timer_en  out  1  countdown run
- timer_set  out  1  countdown reload
- led_sel  out  2  LED mux select
- seg_sel  out  2  7-seg mux select
- last_hits, last_blows  out  CW  latched score of last guess
- tries_used  out  TW  guesses checked this game
- best_tries  out  TW  fewest tries over wins since reset; all-ones = none
- lose_cause  out  1  0 = time, 1 = tries
- state_dbg  out  3  current state code

## Operation
- States: START=0, GEN=1, INPUT=2, CHECK=3, RESULT=4, PAUSE=5, WIN=6, LOSE=7.
- Global priority per cycle: rst (async) > again (-> START from any state) > timer_finish (only in INPUT, CHECK, RESULT -> LOSE, lose_cause<=0) > per-state rules.
- START: clear tries_used, last_hits, last_blows; -> GEN next cycle.
- GEN: hold generate_random=1 until rand_ready; then -> INPUT.
- INPUT: btn -> CHECK; else pulse -> PAUSE (resume target INPUT).
- CHECK: check_start high on entry cycle only; wait for check_valid; on it latch hits/blows, tries_used+1, -> RESULT. btn/pulse ignored.
- RESULT: checked in order: last_hits==DIGITS -> WIN (beats timer_finish in same cycle); MAX_TRIES!=0 and tries_used==MAX_TRIES -> LOSE, lose_cause<=1; btn -> INPUT; pulse -> PAUSE (resume target RESULT).
- PAUSE: timer stopped; btn ignored; pulse -> saved resume state. timer_finish ignored.
- WIN: on entry, best_tries <= tries_used if smaller; btn -> START.
- LOSE: btn -> START.
- Moore outputs decoded from registered state: timer_set=1 only START; timer_en=1 in INPUT, CHECK, RESULT; generate_random=1 only GEN; led_sel 11 in RESULT, 01 WIN, 10 LOSE, else 00; seg_sel 11 PAUSE, 01 WIN, 10 LOSE, else 00.
- check_blows is latched unmodified; hits+blows > DIGITS is a checker fault and not corrected.
- tries_used saturates at all-ones when MAX_TRIES=0.

## Timing
- Reset values: state START, timer_set=1, all other 1-bit outputs 0, led_sel=seg_sel=00, last_*=0, tries_used=0, best_tries=all-ones, lose_cause=0.
- All state/register updates on rising clk; outputs follow state with zero added latency.
- btn -> CHECK in 1 cycle; check_start asserted that following cycle, exactly one cycle wide, even if check_valid arrives same cycle.
- check_valid in CHECK entry cycle is accepted; RESULT next cycle.
- again mid-CHECK abandons handshake; a late check_valid outside CHECK is ignored.
- again and btn same cycle: again wins. pulse and btn same cycle in INPUT/RESULT: btn wins.
- best_tries survives again, cleared only by rst.

## Test plan
- Reset, rand_ready after 3 cycles -> START 1 cycle, GEN 3 cycles, INPUT; timer_set high only in START.
- DIGITS=4: btn, check_valid with hits=4 -> check_start 1 cycle, RESULT, then WIN, led_sel=seg_sel=01, tries_used=1, best_tries=1.
- MAX_TRIES=3: three guesses hits=1 blows=2 -> after third RESULT, LOSE, lose_cause=1, seg_sel=10.
- pulse in RESULT -> PAUSE, timer_en=0, seg_sel=11, btn ignored; pulse -> RESULT, last_hits unchanged.
- timer_finish in INPUT -> LOSE, lose_cause=0; timer_finish same cycle as RESULT with hits=4 -> WIN.
- again during CHECK with check_valid next cycle -> START, tries_used=0; stray check_valid ignored; second game won in 2 tries leaves best_tries=1.
